// File: rtl/anti_theft_fsm.sv
// Vehicle alarm controller: arms/disarms on ignition and door sensors, drives siren, LED and timer start.
// Latency: every output is registered; a decision on inputs at edge N is visible from cycle N+1.
// No backpressure: reacts to every input every cycle; the timer is loaded with a one-cycle start pulse.
module anti_theft_fsm #(
  parameter logic [3:0] DEF_ARM_DELAY       = 4'd6,
  parameter logic [3:0] DEF_DRIVER_DELAY    = 4'd8,
  parameter logic [3:0] DEF_PASSENGER_DELAY = 4'd15,
  parameter logic [3:0] DEF_ALARM_ON        = 4'd10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ignition,
  input  logic       door_driver,
  input  logic       door_pass,
  input  logic       reprogram,
  input  logic [1:0] time_param_sel,
  input  logic [3:0] time_value,
  input  logic       expired,
  input  logic       one_hz_enable,
  output logic [3:0] value,
  output logic       start_timer,
  output logic       siren_enable,
  output logic       status_led,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    ST_ARMED       = 3'd0,
    ST_TRIGGERED   = 3'd1,
    ST_SOUND_ALARM = 3'd2,
    ST_ALARM_HOLD  = 3'd3,
    ST_DISARMED    = 3'd4,
    ST_WAIT_OPEN   = 3'd5,
    ST_WAIT_CLOSE  = 3'd6,
    ST_ARM_DELAY   = 3'd7
  } state_e;

  // Parameter slots: 0 arm delay, 1 driver delay, 2 passenger delay, 3 alarm hold.
  localparam int P_ARM = 0;
  localparam int P_DRV = 1;
  localparam int P_PAS = 2;
  localparam int P_ALM = 3;

  state_e     state_q, state_d;
  logic [3:0] value_q, value_d;
  logic       start_q, start_d;
  logic       siren_q, siren_d;
  logic       led_q,   led_d;
  logic [3:0] param_q [4];
  logic [3:0] param_d [4];

  logic door_open;
  logic expired_ok;

  function automatic logic [3:0] def_value(input logic [1:0] sel);
    case (sel)
      2'd0:    def_value = DEF_ARM_DELAY;
      2'd1:    def_value = DEF_DRIVER_DELAY;
      2'd2:    def_value = DEF_PASSENGER_DELAY;
      default: def_value = DEF_ALARM_ON;
    endcase
  endfunction

  assign door_open  = door_driver | door_pass;
  // An expiry seen while our own start pulse is out belongs to the previous interval.
  assign expired_ok = expired & ~start_q;

  // State, parameter and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_ARMED;
      value_q    <= 4'd0;
      start_q    <= 1'b0;
      siren_q    <= 1'b0;
      led_q      <= 1'b0;
      param_q[0] <= DEF_ARM_DELAY;
      param_q[1] <= DEF_DRIVER_DELAY;
      param_q[2] <= DEF_PASSENGER_DELAY;
      param_q[3] <= DEF_ALARM_ON;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      start_q <= start_d;
      siren_q <= siren_d;
      led_q   <= led_d;
      param_q <= param_d;
    end
  end

  // Next state, timer interval and parameter writes, in transition priority order.
  always_comb begin
    state_d = state_q;
    value_d = value_q;
    start_d = 1'b0;
    param_d = param_q;
    if (reprogram) begin
      param_d[time_param_sel] = (time_value == 4'd0) ? def_value(time_param_sel) : time_value;
      state_d = ST_ARMED;
    end else if (ignition && (state_q != ST_DISARMED)) begin
      state_d = ST_DISARMED;
    end else begin
      case (state_q)
        ST_ARMED: if (door_open) begin
          state_d = ST_TRIGGERED;
          start_d = 1'b1;
          value_d = door_driver ? param_q[P_DRV] : param_q[P_PAS];
        end
        ST_TRIGGERED: if (expired_ok) state_d = ST_SOUND_ALARM;
        ST_SOUND_ALARM: if (!door_open) begin
          state_d = ST_ALARM_HOLD;
          start_d = 1'b1;
          value_d = param_q[P_ALM];
        end
        ST_ALARM_HOLD: begin
          if (door_open)       state_d = ST_SOUND_ALARM;
          else if (expired_ok) state_d = ST_ARMED;
        end
        ST_DISARMED:  if (!ignition)  state_d = ST_WAIT_OPEN;
        ST_WAIT_OPEN: if (door_driver) state_d = ST_WAIT_CLOSE;
        ST_WAIT_CLOSE: if (!door_driver) begin
          state_d = ST_ARM_DELAY;
          start_d = 1'b1;
          value_d = param_q[P_ARM];
        end
        ST_ARM_DELAY: begin
          if (door_driver)     state_d = ST_WAIT_CLOSE;
          else if (expired_ok) state_d = ST_ARMED;
        end
        default: state_d = ST_ARMED;
      endcase
    end
  end

  // Siren and LED follow the state being entered; LED blinks only while staying armed.
  always_comb begin
    siren_d = (state_d == ST_SOUND_ALARM) || (state_d == ST_ALARM_HOLD);
    led_d   = 1'b0;
    case (state_d)
      ST_ARMED:       led_d = (state_q == ST_ARMED) ? (led_q ^ one_hz_enable) : 1'b0;
      ST_TRIGGERED,
      ST_SOUND_ALARM,
      ST_ALARM_HOLD:  led_d = 1'b1;
      default:        led_d = 1'b0;
    endcase
  end

  assign value        = value_q;
  assign start_timer  = start_q;
  assign siren_enable = siren_q;
  assign status_led   = led_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_anti_theft_fsm.sv
// Bench for anti_theft_fsm: directed scenarios then random stimulus against a reference model.
// Expected outputs are queued per cycle at drive time and popped by an independent monitor.
// Asynchronous reset is checked directly between clock edges.
module tb_anti_theft_fsm;

  logic       clock = 1'b0;
  logic       reset;
  logic       ignition, door_driver, door_pass, reprogram;
  logic [1:0] time_param_sel;
  logic [3:0] time_value;
  logic       expired, one_hz_enable;
  logic [3:0] value;
  logic       start_timer, siren_enable, status_led;
  logic [2:0] state_dbg;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  anti_theft_fsm dut (
    .clock          (clock),
    .reset          (reset),
    .ignition       (ignition),
    .door_driver    (door_driver),
    .door_pass      (door_pass),
    .reprogram      (reprogram),
    .time_param_sel (time_param_sel),
    .time_value     (time_value),
    .expired        (expired),
    .one_hz_enable  (one_hz_enable),
    .value          (value),
    .start_timer    (start_timer),
    .siren_enable   (siren_enable),
    .status_led     (status_led),
    .state_dbg      (state_dbg)
  );

  // Mode names for the reference model.
  localparam int ARMED = 0, TRIG = 1, SOUND = 2, HOLD = 3;
  localparam int DIS = 4, WOPEN = 5, WCLOSE = 6, ADELAY = 7;

  typedef struct {
    int st;
    int val;
    int start;
    int siren;
    int led;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state.
  int m_st, m_val, m_start, m_led;
  int prm[4];
  int dflt[4];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    dflt  = '{6, 8, 15, 10};
    prm   = dflt;
    m_st  = ARMED;
    m_val = 0;
    m_start = 0;
    m_led = 0;
  endtask

  // One clock of the alarm rules applied to the inputs currently driven.
  task automatic model_step();
    int ns, iv, go;
    bit open, fresh_exp;
    ns = m_st;
    iv = m_val;
    go = 0;
    open = door_driver || door_pass;
    fresh_exp = expired && (m_start == 0);
    if (reprogram) begin
      prm[time_param_sel] = (time_value == 0) ? dflt[time_param_sel] : int'(time_value);
      ns = ARMED;
    end else if (ignition && m_st != DIS) begin
      ns = DIS;
    end else if (m_st == ARMED && open) begin
      ns = TRIG; go = 1; iv = door_driver ? prm[1] : prm[2];
    end else if (m_st == TRIG && fresh_exp) begin
      ns = SOUND;
    end else if (m_st == SOUND && !open) begin
      ns = HOLD; go = 1; iv = prm[3];
    end else if (m_st == HOLD) begin
      if (open) ns = SOUND;
      else if (fresh_exp) ns = ARMED;
    end else if (m_st == DIS && !ignition) begin
      ns = WOPEN;
    end else if (m_st == WOPEN && door_driver) begin
      ns = WCLOSE;
    end else if (m_st == WCLOSE && !door_driver) begin
      ns = ADELAY; go = 1; iv = prm[0];
    end else if (m_st == ADELAY) begin
      if (door_driver) ns = WCLOSE;
      else if (fresh_exp) ns = ARMED;
    end
    if (ns == TRIG || ns == SOUND || ns == HOLD) m_led = 1;
    else if (ns == ARMED) m_led = (m_st == ARMED) ? (m_led ^ int'(one_hz_enable)) : 0;
    else m_led = 0;
    m_st = ns;
    m_start = go;
    if (go != 0) m_val = iv;
  endtask

  // Drive one cycle of inputs, queue the predicted response, return 2 time units after the edge.
  task automatic cycle(input bit ign, input bit dd, input bit dp, input bit rp,
                       input logic [1:0] sel, input logic [3:0] tv, input bit ex, input bit hz);
    exp_t e;
    ignition = ign; door_driver = dd; door_pass = dp; reprogram = rp;
    time_param_sel = sel; time_value = tv; expired = ex; one_hz_enable = hz;
    model_step();
    e.st = m_st; e.val = m_val; e.start = m_start; e.led = m_led;
    e.siren = (m_st == SOUND || m_st == HOLD) ? 1 : 0;
    exp_q.push_back(e);
    @(posedge clock);
    #2;
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 2'd0, 4'd0, 0, 0);
  endtask

  // Monitor: every cycle the DUT presents a response, compare it against the oldest prediction.
  always @(posedge clock) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("mon_state", int'(state_dbg), e.st);
      chk("mon_value", int'(value), e.val);
      chk("mon_start", int'(start_timer), e.start);
      chk("mon_siren", int'(siren_enable), e.siren);
      chk("mon_led",   int'(status_led), e.led);
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_state"}, int'(state_dbg), 0);
    chk({tag, "_value"}, int'(value), 0);
    chk({tag, "_start"}, int'(start_timer), 0);
    chk({tag, "_siren"}, int'(siren_enable), 0);
    chk({tag, "_led"},   int'(status_led), 0);
  endtask

  initial begin
    reset = 1'b0;
    ignition = 0; door_driver = 0; door_pass = 0; reprogram = 0;
    time_param_sel = 2'd0; time_value = 4'd0; expired = 0; one_hz_enable = 0;
    model_reset();
    #2;
    check_reset_outputs("por");
    #10 reset = 1'b1;

    // Passenger door trigger, then expiry into the siren.
    cycle(0, 0, 1, 0, 2'd0, 4'd0, 0, 0);
    chk("pass_trig_state", int'(state_dbg), 1);
    chk("pass_trig_value", int'(value), 15);
    chk("pass_trig_start", int'(start_timer), 1);
    cycle(0, 0, 1, 0, 2'd0, 4'd0, 0, 0);
    chk("pass_trig_start_once", int'(start_timer), 0);
    cycle(0, 0, 1, 0, 2'd0, 4'd0, 1, 0);
    chk("sound_state", int'(state_dbg), 2);
    chk("sound_siren", int'(siren_enable), 1);
    cycle(0, 0, 1, 0, 2'd0, 4'd0, 0, 0);
    // Doors close: hold; reopen together with expiry returns to the siren.
    idle();
    chk("hold_state", int'(state_dbg), 3);
    chk("hold_value", int'(value), 10);
    idle();
    cycle(0, 0, 1, 0, 2'd0, 4'd0, 1, 0);
    chk("reopen_state", int'(state_dbg), 2);
    chk("reopen_siren", int'(siren_enable), 1);
    idle();
    idle();
    cycle(0, 0, 0, 0, 2'd0, 4'd0, 1, 0);
    chk("hold_exp_state", int'(state_dbg), 0);
    // Both doors at once take the driver delay; ignition disarms.
    cycle(0, 1, 1, 0, 2'd0, 4'd0, 0, 0);
    chk("both_doors_value", int'(value), 8);
    cycle(1, 0, 0, 0, 2'd0, 4'd0, 0, 0);
    chk("disarm_state", int'(state_dbg), 4);
    chk("disarm_siren", int'(siren_enable), 0);
    chk("disarm_led", int'(status_led), 0);
    // Arming sequence with a door reopen during the arm delay.
    idle();
    chk("wait_open_state", int'(state_dbg), 5);
    cycle(0, 1, 0, 0, 2'd0, 4'd0, 0, 0);
    chk("wait_close_state", int'(state_dbg), 6);
    idle();
    chk("arm_delay_state", int'(state_dbg), 7);
    chk("arm_delay_value", int'(value), 6);
    cycle(0, 1, 0, 0, 2'd0, 4'd0, 1, 0);
    chk("arm_reopen_state", int'(state_dbg), 6);
    idle();
    idle();
    cycle(0, 0, 0, 0, 2'd0, 4'd0, 1, 0);
    chk("armed_again_state", int'(state_dbg), 0);
    chk("armed_again_led", int'(status_led), 0);
    cycle(0, 0, 0, 0, 2'd0, 4'd0, 0, 1);
    chk("armed_blink_led", int'(status_led), 1);
    // Reprogram the driver delay from the siren state, then restore it with a zero write.
    cycle(0, 1, 0, 0, 2'd0, 4'd0, 0, 0);
    cycle(0, 1, 0, 0, 2'd0, 4'd0, 0, 0);
    cycle(0, 1, 0, 0, 2'd0, 4'd0, 1, 0);
    chk("pre_reprog_state", int'(state_dbg), 2);
    cycle(0, 1, 0, 1, 2'd1, 4'd3, 0, 0);
    chk("reprog_state", int'(state_dbg), 0);
    chk("reprog_siren", int'(siren_enable), 0);
    cycle(0, 1, 0, 0, 2'd0, 4'd0, 0, 0);
    chk("reprog_value", int'(value), 3);
    cycle(0, 0, 0, 1, 2'd1, 4'd0, 0, 0);
    cycle(0, 1, 0, 0, 2'd0, 4'd0, 0, 0);
    chk("reprog_default_value", int'(value), 8);
    // Asynchronous reset between edges while triggered.
    #3 reset = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    ignition = 0; door_driver = 0; door_pass = 0; reprogram = 0; expired = 0; one_hz_enable = 0;
    @(posedge clock);
    #2 reset = 1'b1;

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 9) == 0, $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3,
            $urandom_range(0, 29) == 0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
            $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0);
    end

    idle();
    @(posedge clock);
    #2;
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/anti_theft_fsm.md
# anti_theft_fsm

Controller for the vehicle alarm. It watches the ignition and door sensors, decides when the alarm is armed, triggered, sounding or disarmed, and drives the siren and status LED. It sits opposite `timer` on the timing interface: it chooses the interval, issues `value` and `start_timer`, and consumes `expired` and `one_hz_enable`. It also holds the four user-programmable time parameters.

## Interface
- `DEF_ARM_DELAY`, 6: default arming delay, in seconds (4-bit).
- `DEF_DRIVER_DELAY`, 8: default driver-door countdown, in seconds.
- `DEF_PASSENGER_DELAY`, 15: default passenger-door countdown, in seconds.
- `DEF_ALARM_ON`, 10: default siren hold time after all doors close, in seconds.
- `clock`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low (asserted at 0).
- `ignition`  in  1  ignition switch on.
- `door_driver`  in  1  driver door open.
- `door_pass`  in  1  passenger door open.
- `reprogram`  in  1  single-cycle strobe that writes a parameter.
- `time_param_sel`  in  2  parameter select: 00 arm, 01 driver, 10 passenger, 11 alarm_on.
- `time_value`  in  4  new parameter value, in seconds.
- `expired`  in  1  from `timer`; the current interval has elapsed.
- `one_hz_enable`  in  1  from `timer`; one-cycle pulse once per second.
- `value`  out  4  interval length sent to `timer`.
- `start_timer`  out  1  one-cycle pulse that loads and starts `timer`.
- `siren_enable`  out  1  siren request; the siren block applies the half-Hz modulation.
- `status_led`  out  1  status LED.
- `state_dbg`  out  3  current state encoding.

## Operation
- All inputs are synchronous to `clock` and debounced upstream. The block has one clock domain.
- Reset values: state ARMED (000); parameters = DEF_*; `value`=0, `start_timer`=0, `siren_enable`=0, `status_led`=0.
- State encodings:
  - ARMED=0, TRIGGERED=1, SOUND_ALARM=2, ALARM_HOLD=3
  - DISARMED=4, WAIT_OPEN=5, WAIT_CLOSE=6, ARM_DELAY=7
- A door counts as open when `door_driver` or `door_pass` is high.
- Transitions (priority follows the order listed):
  - `reprogram`=1 in any state: write the parameter, then go to ARMED with no timer start.
  - `ignition`=1 in any state other than DISARMED: go to DISARMED.
  - ARMED, door open: go to TRIGGERED and start the timer. The interval is the driver delay if `door_driver`=1 (this includes both doors opening in the same cycle); otherwise it is the passenger delay.
  - TRIGGERED, `expired`: go to SOUND_ALARM.
  - SOUND_ALARM, all doors closed: go to ALARM_HOLD and start the timer with alarm_on.
  - ALARM_HOLD, a door reopens: go to SOUND_ALARM. This check takes priority over `expired` in the same cycle.
  - ALARM_HOLD, `expired`: go to ARMED.
  - DISARMED, `ignition`=0: go to WAIT_OPEN.
  - WAIT_OPEN, `door_driver`=1: go to WAIT_CLOSE.
  - WAIT_CLOSE, `door_driver`=0: go to ARM_DELAY and start the timer with the arm delay.
  - ARM_DELAY, `door_driver`=1: go to WAIT_CLOSE. This check takes priority over `expired`.
  - ARM_DELAY, `expired`: go to ARMED.
- Parameter write: `param[time_param_sel]` is loaded with `time_value`. A `time_value` of 0 loads the DEF_* value for that slot instead.
- `siren_enable` is 1 only in SOUND_ALARM and ALARM_HOLD.
- `status_led` behaviour:
  - ARMED: toggles on each `one_hz_enable` pulse (0.5 Hz blink). It is cleared to 0 on entry to ARMED.
  - TRIGGERED, SOUND_ALARM, ALARM_HOLD: held at 1.
  - Disarmed-path states: held at 0.

## Timing
- All outputs are registered.
- A transition is decided from inputs at clock edge N. From cycle N+1:
  - `state_dbg`, `siren_enable` and `status_led` reflect the new state.
  - `start_timer` is high for exactly that one cycle.
  - `value` is loaded in the same cycle as `start_timer`.
- `value` stays stable until the next timer start. It is not cleared on leaving a timed state.
- `expired` handling:
  - It is sampled only in TRIGGERED, ALARM_HOLD and ARM_DELAY.
  - It is ignored in the cycle `start_timer` is high, which covers a stale `expired` from the previous interval.
  - It is ignored in all other states.
- A parameter write takes effect on the next timer start. An interval already running keeps its length.
- Reset asserted mid-operation forces the reset values asynchronously. After release, the next start is never a partial timer start.
- `reprogram` held high for several cycles writes once per cycle and keeps the state at ARMED.

## Test plan
- Reset, then `door_pass`=1 for 1 cycle: TRIGGERED, `value`=15, one `start_timer` pulse. Inject `expired`: `siren_enable`=1 one cycle later, `state_dbg`=2.
- SOUND_ALARM, then close the doors: ALARM_HOLD with `value`=10. Reopen a door in the same cycle that `expired` arrives: returns to SOUND_ALARM, siren stays 1.
- ARMED, then both doors open in the same cycle: `value`=8. Raise `ignition` before `expired`: DISARMED, `siren_enable`=0, `status_led`=0.
- Disarm sequence: `ignition` off, driver door open, driver door closed. ARM_DELAY with `value`=6. Reopen the door before expiry: WAIT_CLOSE. Close again and inject `expired`: ARMED, LED toggles on the next `one_hz_enable`.
- `reprogram` with sel=01 and `time_value`=3 in SOUND_ALARM: ARMED, siren 0. The next driver trigger gives `value`=3. Reprogram with `time_value`=0: the next driver trigger gives `value`=8.
- Assert `reset` low mid-TRIGGERED, asynchronously between edges: all outputs return to their reset values immediately, `state_dbg`=0.
